rider_balance_detect: RTL and testbench



---
 rtl/rider_balance_detect.sv | 159 +++++++++++++++
 tb/tb_rider_balance_detect.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rider_balance_detect.sv
// -----------------------------------------------------------------------------
// rider_balance_detect
//   Watches the held load-cell and battery readings and decides when a rider
//   is mounted and balanced long enough to enable steering. Flags a dismount
//   with a one-clock pulse and reports a low battery.
//
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     lft_ld     latest left load-cell reading (12 bit)
//     rght_ld    latest right load-cell reading (12 bit)
//     batt       latest battery reading (12 bit)
//     en_steer   high while steering is enabled (registered)
//     rider_off  one-clock pulse after a dismount (registered)
//     batt_low   registered batt < BATT_THRES
// -----------------------------------------------------------------------------
module rider_balance_detect #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter logic [25:0] TMR_FULL     = 26'h3FF_FFFF,
  parameter logic [11:0] BATT_THRES   = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic        en_steer,
  output logic        rider_off,
  output logic        batt_low
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT     = 2'b01,
    STEER_EN = 2'b10
  } state_t;

  // Thresholds widened to the 13-bit sum width so the compares never truncate.
  localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

  state_t      state_r;
  state_t      nxt_state_s;
  logic [25:0] timer_r;
  logic        clr_tmr_s;
  logic        inc_tmr_s;
  logic        off_pulse_s;
  logic        en_steer_r;
  logic        rider_off_r;
  logic        batt_low_r;

  logic [12:0] sum_s;
  logic [11:0] diff_s;
  logic        sum_gt_min_s;
  logic        sum_lt_min_s;
  logic        diff_gt_1_4_s;
  logic        diff_gt_15_16_s;

  // Weight sum, absolute imbalance and the threshold flags derived from them.
  always_comb begin
    sum_s = {1'b0, lft_ld} + {1'b0, rght_ld};
    if (lft_ld >= rght_ld) begin
      diff_s = lft_ld - rght_ld;
    end else begin
      diff_s = rght_ld - lft_ld;
    end
    // Between SUM_LO and SUM_HI both flags stay low, so the FSM holds.
    sum_gt_min_s    = (sum_s > SUM_HI);
    sum_lt_min_s    = (sum_s < SUM_LO);
    diff_gt_1_4_s   = ({1'b0, diff_s} > (sum_s >> 2));
    diff_gt_15_16_s = ({1'b0, diff_s} > (sum_s - (sum_s >> 4)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Next-state logic; a light rider always wins over any lean condition.
  always_comb begin
    nxt_state_s = state_r;
    clr_tmr_s   = 1'b0;
    inc_tmr_s   = 1'b0;
    off_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sum_gt_min_s) begin
          nxt_state_s = WAIT;
          clr_tmr_s   = 1'b1;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      WAIT: begin
        if (sum_lt_min_s) begin
          nxt_state_s = IDLE;
          off_pulse_s = 1'b1;
        end else if (diff_gt_1_4_s) begin
          clr_tmr_s   = 1'b1;
        end else if (timer_r == TMR_FULL) begin
          nxt_state_s = STEER_EN;
        end else begin
          inc_tmr_s   = 1'b1;
        end
      end
      STEER_EN: begin
        if (sum_lt_min_s) begin
          nxt_state_s = IDLE;
          off_pulse_s = 1'b1;
        end else if (diff_gt_15_16_s) begin
          nxt_state_s = WAIT;
          clr_tmr_s   = 1'b1;
        end else begin
          nxt_state_s = STEER_EN;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // Settle timer: clears on request, counts in WAIT, saturates at TMR_FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= 26'd0;
    end else if (clr_tmr_s) begin
      timer_r <= 26'd0;
    end else if (inc_tmr_s && (timer_r != TMR_FULL)) begin
      timer_r <= timer_r + 26'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Registered outputs; en_steer tracks the state being entered so it is
  // high on exactly the cycles the FSM sits in STEER_EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_steer_r  <= 1'b0;
      rider_off_r <= 1'b0;
      batt_low_r  <= 1'b0;
    end else begin
      en_steer_r  <= (nxt_state_s == STEER_EN);
      rider_off_r <= off_pulse_s;
      batt_low_r  <= (batt < BATT_THRES);
    end
  end

  assign en_steer  = en_steer_r;
  assign rider_off = rider_off_r;
  assign batt_low  = batt_low_r;

endmodule

// File: tb/tb_rider_balance_detect.sv
// -----------------------------------------------------------------------------
// tb_rider_balance_detect
//   Self-checking bench for rider_balance_detect with TMR_FULL=100. A
//   behavioural rider model (mounted / steering / settle count) predicts the
//   three outputs every clock; directed scenarios plus randomized holds.
// -----------------------------------------------------------------------------
module tb_rider_balance_detect;

  localparam int TMR = 100;

  logic        clk;
  logic        rst_n;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        en_steer;
  logic        rider_off;
  logic        batt_low;

  int total;
  int bad;

  // behavioural reference model
  bit m_mounted;
  bit m_steer;
  int m_cnt;
  bit m_off;
  bit m_blow;

  rider_balance_detect #(
    .TMR_FULL(26'd100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .en_steer (en_steer),
    .rider_off(rider_off),
    .batt_low (batt_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mounted = 0; m_steer = 0; m_cnt = 0; m_off = 0; m_blow = 0;
  endtask

  // Advance one clock and update the rider model from the inputs it saw.
  task automatic tick();
    int s, d;
    @(posedge clk);
    s = int'(lft_ld) + int'(rght_ld);
    d = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
    m_off = 0;
    if (!m_mounted) begin
      if (s > 'h240) begin m_mounted = 1; m_cnt = 0; end
    end else if (s < 'h1C0) begin
      m_mounted = 0; m_steer = 0; m_off = 1;
    end else if (!m_steer) begin
      if (d > s / 4) m_cnt = 0;
      else if (m_cnt == TMR) m_steer = 1;
      else m_cnt++;
    end else if (d > s - s / 16) begin
      m_steer = 0; m_cnt = 0;
    end
    m_blow = (batt < 12'h800);
    #1;
  endtask

  task automatic set_ld(input int l, input int r);
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    batt  = 12'h900;
    set_ld(0, 0);
    model_reset();
    #23;
    total++; if (en_steer !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", en_steer); end
    total++; if (rider_off !== 1'b0) begin bad++; $display("FAIL reset_off got=%0b want=0", rider_off); end
    total++; if (batt_low !== 1'b0) begin bad++; $display("FAIL reset_blow got=%0b want=0", batt_low); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_mount();
    int rise = -1;
    set_ld('h150, 'h150);
    for (int i = 1; i <= 130; i++) begin
      tick();
      if (rise < 0 && en_steer === 1'b1) rise = i;
      total++;
      if ({en_steer, rider_off, batt_low} !== {m_steer, m_off, m_blow}) begin
        bad++; $display("FAIL mount cyc=%0d got=%b want=%b", i, {en_steer, rider_off, batt_low}, {m_steer, m_off, m_blow});
      end
    end
    total++; if (rise != 102) begin bad++; $display("FAIL mount_latency got=%0d want=102", rise); end
  endtask

  task automatic test_hysteresis();
    int offs = 0;
    set_ld('h100, 'h100);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({en_steer, rider_off} !== 2'b10) begin
        bad++; $display("FAIL hyst_band got=%b want=10", {en_steer, rider_off});
      end
    end
    set_ld('hD0, 'hD0);
    for (int i = 0; i < 6; i++) begin
      tick();
      offs += int'(rider_off);
      total++;
      if ({en_steer, rider_off} !== {m_steer, m_off}) begin
        bad++; $display("FAIL hyst_exit cyc=%0d got=%b want=%b", i, {en_steer, rider_off}, {m_steer, m_off});
      end
    end
    total++; if (offs != 1) begin bad++; $display("FAIL hyst_pulse_count got=%0d want=1", offs); end
  endtask

  task automatic test_settle_imbalance();
    int rise = -1;
    set_ld('h150, 'h150);
    for (int i = 0; i < 50; i++) tick();
    set_ld('h200, 'h080);
    for (int i = 0; i < 5; i++) tick();
    set_ld('h150, 'h150);
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (rise < 0 && en_steer === 1'b1) rise = i;
      total++;
      if ({en_steer, rider_off} !== {m_steer, m_off}) begin
        bad++; $display("FAIL settle cyc=%0d got=%b want=%b", i, {en_steer, rider_off}, {m_steer, m_off});
      end
    end
    total++; if (rise != 101) begin bad++; $display("FAIL settle_restart got=%0d want=101", rise); end
  endtask

  task automatic test_lean();
    set_ld('h200, 'h080);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({en_steer, rider_off} !== 2'b10) begin
        bad++; $display("FAIL lean_moderate got=%b want=10", {en_steer, rider_off});
      end
    end
    set_ld('h2F0, 'h008);
    tick();
    total++;
    if ({en_steer, rider_off} !== 2'b00) begin
      bad++; $display("FAIL lean_hard got=%b want=00", {en_steer, rider_off});
    end
    // back to balance and re-settle to STEER_EN
    set_ld('h150, 'h150);
    for (int i = 0; i < 105; i++) tick();
    total++; if (en_steer !== 1'b1) begin bad++; $display("FAIL lean_resettle got=%0b want=1", en_steer); end
  endtask

  task automatic test_simultaneous();
    set_ld('h1B0, 'h000);
    tick();
    total++;
    if ({en_steer, rider_off} !== 2'b01) begin
      bad++; $display("FAIL simul got=%b want=01", {en_steer, rider_off});
    end
    set_ld('h150, 'h150);
    for (int i = 1; i <= 104; i++) begin
      tick();
      total++;
      if ({en_steer, rider_off} !== {m_steer, m_off}) begin
        bad++; $display("FAIL simul_after cyc=%0d got=%b want=%b", i, {en_steer, rider_off}, {m_steer, m_off});
      end
    end
  endtask

  task automatic test_boundary();
    set_ld('h0E0, 'h0E0);            // sum 0x1C0: hold region, stay steering
    for (int i = 0; i < 3; i++) tick();
    total++; if ({en_steer, rider_off} !== 2'b10) begin bad++; $display("FAIL bnd_lo_hold got=%b want=10", {en_steer, rider_off}); end
    set_ld('h0E0, 'h0DF);            // sum 0x1BF: dismount
    tick();
    total++; if ({en_steer, rider_off} !== 2'b01) begin bad++; $display("FAIL bnd_lo_exit got=%b want=01", {en_steer, rider_off}); end
    set_ld('h120, 'h120);            // sum 0x240: not above the mount threshold
    for (int i = 0; i < 110; i++) tick();
    total++; if (en_steer !== 1'b0) begin bad++; $display("FAIL bnd_hi_hold got=%0b want=0", en_steer); end
    set_ld('h190, 'h0F0);            // sum 0x280, diff == sum/4: not a lean
    for (int i = 1; i <= 104; i++) begin
      tick();
      total++;
      if ({en_steer, rider_off} !== {m_steer, m_off}) begin
        bad++; $display("FAIL bnd_quarter cyc=%0d got=%b want=%b", i, {en_steer, rider_off}, {m_steer, m_off});
      end
    end
  endtask

  task automatic test_batt();
    batt = 12'h7FF;
    #1;
    total++; if (batt_low !== 1'b0) begin bad++; $display("FAIL batt_early got=%0b want=0", batt_low); end
    tick();
    total++; if (batt_low !== 1'b1) begin bad++; $display("FAIL batt_low got=%0b want=1", batt_low); end
    batt = 12'h800;
    tick();
    total++; if (batt_low !== 1'b0) begin bad++; $display("FAIL batt_thres got=%0b want=0", batt_low); end
  endtask

  task automatic test_random();
    int hold, mode, base;
    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin base = $urandom_range('h100, 'h400); set_ld(base, base - $urandom_range(0, base / 2)); end
        1: set_ld($urandom_range(0, 4095), $urandom_range(0, 4095));
        2: set_ld($urandom_range(0, 'hF0), $urandom_range(0, 'hF0));
        default: begin base = $urandom_range('h200, 'h600); set_ld(base, $urandom_range(0, 'h20)); end
      endcase
      batt = 12'($urandom_range('h700, 'h900));
      hold = $urandom_range(1, 130);
      for (int i = 0; i < hold; i++) begin
        tick();
        total++;
        if ({en_steer, rider_off, batt_low} !== {m_steer, m_off, m_blow}) begin
          bad++; $display("FAIL random n=%0d got=%b want=%b", n, {en_steer, rider_off, batt_low}, {m_steer, m_off, m_blow});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int offs = 0;
    batt = 12'h900;
    set_ld('h150, 'h150);
    for (int i = 0; i < 240 && !m_steer; i++) tick();
    tick();
    total++; if (en_steer !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0b want=1", en_steer); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (en_steer !== 1'b0) begin bad++; $display("FAIL arst_async got=%0b want=0", en_steer); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_ld('h000, 'h000);
    for (int i = 0; i < 5; i++) begin
      tick();
      offs += int'(rider_off);
      total++;
      if ({en_steer, rider_off} !== {m_steer, m_off}) begin
        bad++; $display("FAIL arst_after got=%b want=%b", {en_steer, rider_off}, {m_steer, m_off});
      end
    end
    total++; if (offs != 0) begin bad++; $display("FAIL arst_pulse got=%0d want=0", offs); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mount();
    test_hysteresis();
    test_settle_imbalance();
    test_lean();
    test_simultaneous();
    test_boundary();
    test_batt();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
